// File: rtl/minisrc_pkg.sv
// Shared constants for the mini-SRC control sequencer: opcodes, ALU codes,
// the sequencer state encoding and the decoded instruction classes.
package minisrc_pkg;

   localparam logic [4:0] OP_LD        = 5'b00000;
   localparam logic [4:0] OP_LDI       = 5'b00001;
   localparam logic [4:0] OP_ST        = 5'b00010;
   localparam logic [4:0] OP_RFMT_LO   = 5'b00011;
   localparam logic [4:0] OP_RFMT_HI   = 5'b01011;
   localparam logic [4:0] OP_ADDI      = 5'b01100;
   localparam logic [4:0] OP_ANDI      = 5'b01101;
   localparam logic [4:0] OP_ORI       = 5'b01110;
   localparam logic [4:0] OP_NOP       = 5'b11010;
   localparam logic [4:0] OP_HALT      = 5'b11011;

   localparam logic [4:0] ALU_ADD      = 5'b00011;
   localparam logic [4:0] ALU_AND      = 5'b01010;
   localparam logic [4:0] ALU_OR       = 5'b01011;

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT, FAULT
   } seq_state_t;

   typedef enum logic [2:0] {
      CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_IMM, CLS_NOP, CLS_HALT, CLS_BAD
   } instr_class_t;

endpackage

// File: rtl/minisrc_instr_decode.sv
// Opcode decoder: classifies an instruction and picks the ALU code used in T4.
module minisrc_instr_decode
   import minisrc_pkg::*;
(
   input  logic [4:0]   opcode,
   output instr_class_t instr_class,
   output logic [4:0]   alu_code
);

   always_comb begin
      instr_class = CLS_BAD;
      alu_code    = 5'b00000;
      case (opcode) inside
         OP_LD:   begin instr_class = CLS_LD;  alu_code = ALU_ADD; end
         OP_LDI:  begin instr_class = CLS_LDI; alu_code = ALU_ADD; end
         OP_ST:   begin instr_class = CLS_ST;  alu_code = ALU_ADD; end
         [OP_RFMT_LO:OP_RFMT_HI]: begin
            instr_class = CLS_ALU;
            alu_code    = opcode;
         end
         OP_ADDI: begin instr_class = CLS_IMM; alu_code = ALU_ADD; end
         OP_ANDI: begin instr_class = CLS_IMM; alu_code = ALU_AND; end
         OP_ORI:  begin instr_class = CLS_IMM; alu_code = ALU_OR;  end
         OP_NOP:  instr_class = CLS_NOP;
         OP_HALT: instr_class = CLS_HALT;
         default: instr_class = CLS_BAD;
      endcase
   end

endmodule

// File: rtl/minisrc_control_sequencer.sv
// Moore control sequencer for the mini-SRC datapath: fetch, decode in T3,
// execute through T7, with memory steps stretched by MEM_WAIT cycles.
module minisrc_control_sequencer
   import minisrc_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int ALU_W    = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic [31:0]      IR_Data,
   output logic             PC_out,
   output logic             PC_in,
   output logic             IncPC,
   output logic             MAR_in,
   output logic             MDR_in,
   output logic             MDR_out,
   output logic             IR_in,
   output logic             Y_in,
   output logic             Z_in,
   output logic             Zlow_out,
   output logic             C_out,
   output logic             Read,
   output logic             Write,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic [ALU_W-1:0] alu_instruction_bits,
   output logic             instr_done,
   output logic             halted,
   output logic             fault
);

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   seq_state_t   state_reg, state_next;
   logic [2:0]   wait_reg, wait_next;
   instr_class_t instr_class;
   logic [4:0]   alu_code;
   logic [4:0]   alu_sel;
   logic         mem_last;
   logic         unused_ir;

   assign unused_ir = ^IR_Data[26:0];
   assign mem_last  = (wait_reg == WAIT_LAST);

   minisrc_instr_decode u_decode (
      .opcode      (IR_Data[31:27]),
      .instr_class (instr_class),
      .alu_code    (alu_code)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= IDLE;
         wait_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wait_next  = 3'd0;
      PC_out = 1'b0; PC_in = 1'b0; IncPC = 1'b0; MAR_in = 1'b0;
      MDR_in = 1'b0; MDR_out = 1'b0; IR_in = 1'b0; Y_in = 1'b0;
      Z_in = 1'b0; Zlow_out = 1'b0; C_out = 1'b0; Read = 1'b0;
      Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      alu_sel    = 5'b00000;
      instr_done = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;

      case (state_reg)
         IDLE: if (run) state_next = T0;
         T0: begin
            PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
            state_next = T1;
         end
         T1: begin
            Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = mem_last;
            if (mem_last) state_next = T2;
            else          wait_next  = wait_reg + 3'd1;
         end
         T2: begin
            MDR_out = 1'b1; IR_in = 1'b1;
            if (instr_class == CLS_NOP) begin
               instr_done = 1'b1;
               state_next = run ? T0 : IDLE;
            end else begin
               state_next = T3;
            end
         end
         T3: begin
            case (instr_class)
               CLS_LD, CLS_LDI, CLS_ST: begin
                  Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; state_next = T4;
               end
               CLS_ALU, CLS_IMM: begin
                  Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; state_next = T4;
               end
               CLS_NOP: begin
                  instr_done = 1'b1;
                  state_next = run ? T0 : IDLE;
               end
               CLS_HALT: state_next = HALT;
               default:  state_next = FAULT;
            endcase
         end
         T4: begin
            alu_sel = alu_code;
            Z_in    = 1'b1;
            if (instr_class == CLS_ALU) begin
               Grc = 1'b1; Rout = 1'b1;
            end else begin
               C_out = 1'b1;
            end
            state_next = T5;
         end
         T5: begin
            Zlow_out = 1'b1;
            if (instr_class == CLS_LD || instr_class == CLS_ST) begin
               MAR_in = 1'b1; state_next = T6;
            end else begin
               Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
               state_next = run ? T0 : IDLE;
            end
         end
         T6: begin
            if (instr_class == CLS_ST) begin
               Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; state_next = T7;
            end else begin
               Read = 1'b1; MDR_in = mem_last;
               if (mem_last) state_next = T7;
               else          wait_next  = wait_reg + 3'd1;
            end
         end
         T7: begin
            if (instr_class == CLS_ST) begin
               Write = 1'b1;
               if (mem_last) begin
                  instr_done = 1'b1;
                  state_next = run ? T0 : IDLE;
               end else begin
                  wait_next = wait_reg + 3'd1;
               end
            end else begin
               MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
               state_next = run ? T0 : IDLE;
            end
         end
         HALT:    halted = 1'b1;
         FAULT:   fault  = 1'b1;
         default: state_next = IDLE;
      endcase
   end

   assign alu_instruction_bits = ALU_W'(alu_sel);

endmodule

// File: tb/tb_minisrc_control_sequencer.sv
// Directed vector bench: one entry per clock cycle of expected Moore outputs,
// plus hand-written halt, fault, reset-abort and MEM_WAIT=2 store sequences.
module tb_minisrc_control_sequencer;

   localparam logic [18:0] B_PC_out   = 19'h40000;
   localparam logic [18:0] B_PC_in    = 19'h20000;
   localparam logic [18:0] B_IncPC    = 19'h10000;
   localparam logic [18:0] B_MAR_in   = 19'h08000;
   localparam logic [18:0] B_MDR_in   = 19'h04000;
   localparam logic [18:0] B_MDR_out  = 19'h02000;
   localparam logic [18:0] B_IR_in    = 19'h01000;
   localparam logic [18:0] B_Y_in     = 19'h00800;
   localparam logic [18:0] B_Z_in     = 19'h00400;
   localparam logic [18:0] B_Zlow_out = 19'h00200;
   localparam logic [18:0] B_C_out    = 19'h00100;
   localparam logic [18:0] B_Read     = 19'h00080;
   localparam logic [18:0] B_Write    = 19'h00040;
   localparam logic [18:0] B_Gra      = 19'h00020;
   localparam logic [18:0] B_Grb      = 19'h00010;
   localparam logic [18:0] B_Grc      = 19'h00008;
   localparam logic [18:0] B_Rin      = 19'h00004;
   localparam logic [18:0] B_Rout     = 19'h00002;
   localparam logic [18:0] B_BAout    = 19'h00001;

   localparam logic [18:0] NONE = 19'h0;
   localparam logic [18:0] F0   = B_PC_out | B_MAR_in | B_IncPC | B_Z_in;
   localparam logic [18:0] F1   = B_Zlow_out | B_PC_in | B_Read | B_MDR_in;
   localparam logic [18:0] F1W  = B_Zlow_out | B_PC_in | B_Read;
   localparam logic [18:0] F2   = B_MDR_out | B_IR_in;
   localparam logic [18:0] M3   = B_Grb | B_BAout | B_Y_in;
   localparam logic [18:0] M4   = B_C_out | B_Z_in;
   localparam logic [18:0] M5   = B_Zlow_out | B_MAR_in;
   localparam logic [18:0] A3   = B_Grb | B_Rout | B_Y_in;
   localparam logic [18:0] A4   = B_Grc | B_Rout | B_Z_in;
   localparam logic [18:0] WB   = B_Zlow_out | B_Gra | B_Rin;

   localparam logic [31:0] IR_LD   = 32'h00080045;
   localparam logic [31:0] IR_ADD  = 32'h18918000;
   localparam logic [31:0] IR_ORI  = 32'h70000000;
   localparam logic [31:0] IR_ST   = 32'h10000000;
   localparam logic [31:0] IR_LDI  = 32'h08000000;
   localparam logic [31:0] IR_NOP  = 32'hD0000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;
   localparam logic [31:0] IR_BAD  = 32'hF8000000;

   typedef struct {
      logic        clr;
      logic        run;
      logic [31:0] ir;
      logic [18:0] ctl;
      logic [4:0]  alu;
      logic        done;
      logic        halted;
      logic        fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        run = 1'b0;
   logic [31:0] ir  = 32'h0;
   logic [18:0] ctl0, ctl1;
   logic [4:0]  alu0, alu1;
   logic        done0, halted0, fault0, done1, halted1, fault1;
   int          n_vec = 0;
   int          n_bad = 0;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   minisrc_control_sequencer #(.MEM_WAIT(0), .ALU_W(5)) dut0 (
      .clk(clk), .clr(clr), .run(run), .IR_Data(ir),
      .PC_out(ctl0[18]), .PC_in(ctl0[17]), .IncPC(ctl0[16]), .MAR_in(ctl0[15]),
      .MDR_in(ctl0[14]), .MDR_out(ctl0[13]), .IR_in(ctl0[12]), .Y_in(ctl0[11]),
      .Z_in(ctl0[10]), .Zlow_out(ctl0[9]), .C_out(ctl0[8]), .Read(ctl0[7]),
      .Write(ctl0[6]), .Gra(ctl0[5]), .Grb(ctl0[4]), .Grc(ctl0[3]),
      .Rin(ctl0[2]), .Rout(ctl0[1]), .BAout(ctl0[0]),
      .alu_instruction_bits(alu0), .instr_done(done0), .halted(halted0), .fault(fault0)
   );

   minisrc_control_sequencer #(.MEM_WAIT(2), .ALU_W(5)) dut1 (
      .clk(clk), .clr(clr), .run(run), .IR_Data(ir),
      .PC_out(ctl1[18]), .PC_in(ctl1[17]), .IncPC(ctl1[16]), .MAR_in(ctl1[15]),
      .MDR_in(ctl1[14]), .MDR_out(ctl1[13]), .IR_in(ctl1[12]), .Y_in(ctl1[11]),
      .Z_in(ctl1[10]), .Zlow_out(ctl1[9]), .C_out(ctl1[8]), .Read(ctl1[7]),
      .Write(ctl1[6]), .Gra(ctl1[5]), .Grb(ctl1[4]), .Grc(ctl1[3]),
      .Rin(ctl1[2]), .Rout(ctl1[1]), .BAout(ctl1[0]),
      .alu_instruction_bits(alu1), .instr_done(done1), .halted(halted1), .fault(fault1)
   );

   function automatic vec_t mk(input logic c, input logic r, input logic [31:0] i,
                               input logic [18:0] ct, input logic [4:0] a,
                               input logic d, input logic h, input logic f);
      vec_t v;
      v.clr = c; v.run = r; v.ir = i; v.ctl = ct; v.alu = a;
      v.done = d; v.halted = h; v.fault = f;
      return v;
   endfunction

   // Drive one cycle's inputs after the falling edge and check the current state's outputs.
   task automatic apply(input vec_t v, input bit sel, input string tag);
      logic [26:0] act, exp;
      @(negedge clk);
      clr = v.clr; run = v.run; ir = v.ir;
      #1;
      act = sel ? {ctl1, alu1, done1, halted1, fault1} : {ctl0, alu0, done0, halted0, fault0};
      exp = {v.ctl, v.alu, v.done, v.halted, v.fault};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ctl=%05h alu=%02h done=%b halted=%b fault=%b, want ctl=%05h alu=%02h done=%b halted=%b fault=%b",
                  tag, act[26:8], act[7:3], act[2], act[1], act[0],
                  exp[26:8], exp[7:3], exp[2], exp[1], exp[0]);
      end else begin
         $display("ok   %s: ctl=%05h alu=%02h done=%b halted=%b fault=%b",
                  tag, act[26:8], act[7:3], act[2], act[1], act[0]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1; run = 1'b0;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      // ld, add, ori, st back to back; ldi then nop end with run=0
      tbl.push_back(mk(0, 0, IR_LD,  NONE, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  NONE, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  F2,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  M3,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  M4,   5'b00011, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  M5,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  B_Read | B_MDR_in, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LD,  B_MDR_out | B_Gra | B_Rin, 5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, F2,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, A3,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, A4,   5'b00011, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ADD, WB,   5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, F2,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, A3,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, M4,   5'b01011, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ORI, WB,   5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  F2,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  M3,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  M4,   5'b00011, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  M5,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  B_Gra | B_Rout | B_MDR_in, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_ST,  B_Write, 5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 1, IR_LDI, F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LDI, F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LDI, F2,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LDI, M3,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_LDI, M4,   5'b00011, 0, 0, 0));
      tbl.push_back(mk(0, 0, IR_LDI, WB,   5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 1, IR_NOP, NONE, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_NOP, F0,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 1, IR_NOP, F1,   5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, IR_NOP, F2,   5'd0, 1, 0, 0));
      tbl.push_back(mk(0, 0, IR_NOP, NONE, 5'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, IR_NOP, NONE, 5'd0, 0, 0, 0));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

      // halt: sticky with run held high, cleared only by clr
      do_reset();
      apply(mk(0, 1, IR_HALT, NONE, 5'd0, 0, 0, 0), 1'b0, "halt.idle");
      apply(mk(0, 1, IR_HALT, F0,   5'd0, 0, 0, 0), 1'b0, "halt.T0");
      apply(mk(0, 1, IR_HALT, F1,   5'd0, 0, 0, 0), 1'b0, "halt.T1");
      apply(mk(0, 1, IR_HALT, F2,   5'd0, 0, 0, 0), 1'b0, "halt.T2");
      apply(mk(0, 1, IR_HALT, NONE, 5'd0, 0, 0, 0), 1'b0, "halt.T3");
      for (int i = 0; i < 3; i++)
         apply(mk(0, 1, IR_LD, NONE, 5'd0, 0, 1, 0), 1'b0, $sformatf("halt.hold%0d", i));
      apply(mk(1, 1, IR_LD, NONE, 5'd0, 0, 1, 0), 1'b0, "halt.clr");
      apply(mk(0, 0, IR_LD, NONE, 5'd0, 0, 0, 0), 1'b0, "halt.cleared");

      // illegal opcode: fault with every control low
      do_reset();
      apply(mk(0, 1, IR_BAD, NONE, 5'd0, 0, 0, 0), 1'b0, "fault.idle");
      apply(mk(0, 1, IR_BAD, F0,   5'd0, 0, 0, 0), 1'b0, "fault.T0");
      apply(mk(0, 1, IR_BAD, F1,   5'd0, 0, 0, 0), 1'b0, "fault.T1");
      apply(mk(0, 1, IR_BAD, F2,   5'd0, 0, 0, 0), 1'b0, "fault.T2");
      apply(mk(0, 1, IR_BAD, NONE, 5'd0, 0, 0, 0), 1'b0, "fault.T3");
      for (int i = 0; i < 3; i++)
         apply(mk(0, 1, IR_LD, NONE, 5'd0, 0, 0, 1), 1'b0, $sformatf("fault.hold%0d", i));
      apply(mk(1, 0, IR_LD, NONE, 5'd0, 0, 0, 1), 1'b0, "fault.clr");
      apply(mk(0, 0, IR_LD, NONE, 5'd0, 0, 0, 0), 1'b0, "fault.cleared");

      // clr in T5 of ld aborts before the T7 register write
      do_reset();
      apply(mk(0, 1, IR_LD, NONE, 5'd0, 0, 0, 0), 1'b0, "abort.idle");
      apply(mk(0, 1, IR_LD, F0,   5'd0, 0, 0, 0), 1'b0, "abort.T0");
      apply(mk(0, 1, IR_LD, F1,   5'd0, 0, 0, 0), 1'b0, "abort.T1");
      apply(mk(0, 1, IR_LD, F2,   5'd0, 0, 0, 0), 1'b0, "abort.T2");
      apply(mk(0, 1, IR_LD, M3,   5'd0, 0, 0, 0), 1'b0, "abort.T3");
      apply(mk(0, 1, IR_LD, M4,   5'b00011, 0, 0, 0), 1'b0, "abort.T4");
      apply(mk(1, 1, IR_LD, M5,   5'd0, 0, 0, 0), 1'b0, "abort.T5clr");
      for (int i = 0; i < 3; i++)
         apply(mk(0, 0, IR_LD, NONE, 5'd0, 0, 0, 0), 1'b0, $sformatf("abort.idle%0d", i));

      // MEM_WAIT=2 store: fetch read and write each held three cycles, 12 total
      do_reset();
      apply(mk(0, 1, IR_ST, NONE, 5'd0, 0, 0, 0), 1'b1, "w2.idle");
      apply(mk(0, 1, IR_ST, F0,   5'd0, 0, 0, 0), 1'b1, "w2.T0");
      apply(mk(0, 1, IR_ST, F1W,  5'd0, 0, 0, 0), 1'b1, "w2.T1a");
      apply(mk(0, 1, IR_ST, F1W,  5'd0, 0, 0, 0), 1'b1, "w2.T1b");
      apply(mk(0, 1, IR_ST, F1,   5'd0, 0, 0, 0), 1'b1, "w2.T1c");
      apply(mk(0, 1, IR_ST, F2,   5'd0, 0, 0, 0), 1'b1, "w2.T2");
      apply(mk(0, 1, IR_ST, M3,   5'd0, 0, 0, 0), 1'b1, "w2.T3");
      apply(mk(0, 1, IR_ST, M4,   5'b00011, 0, 0, 0), 1'b1, "w2.T4");
      apply(mk(0, 1, IR_ST, M5,   5'd0, 0, 0, 0), 1'b1, "w2.T5");
      apply(mk(0, 1, IR_ST, B_Gra | B_Rout | B_MDR_in, 5'd0, 0, 0, 0), 1'b1, "w2.T6");
      apply(mk(0, 0, IR_ST, B_Write, 5'd0, 0, 0, 0), 1'b1, "w2.T7a");
      apply(mk(0, 0, IR_ST, B_Write, 5'd0, 0, 0, 0), 1'b1, "w2.T7b");
      apply(mk(0, 0, IR_ST, B_Write, 5'd0, 1, 0, 0), 1'b1, "w2.T7c");
      apply(mk(0, 0, IR_ST, NONE,    5'd0, 0, 0, 0), 1'b1, "w2.idle_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
